// File: rtl/reset_sequencer.sv
// reset_sequencer: ordered ADC -> DSP -> core reset release with run watchdog.
// Optional feature macro: RESET_SEQ_WATCHDOG_EN (max_cycles timeout / FAIL).
module reset_sequencer #(
    parameter int CNT_W = 16,
    parameter int CYC_W = 64
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             soft_reset,
    input  logic [CNT_W-1:0] adc_delay,
    input  logic [CNT_W-1:0] dsp_delay,
    input  logic [CNT_W-1:0] core_delay,
    input  logic [CYC_W-1:0] max_cycles,
    input  logic             success,
    output logic             adc_reset,
    output logic             dsp_reset,
    output logic             core_reset,
    output logic             running,
    output logic             done,
    output logic             failed,
    output logic [CYC_W-1:0] cycle_count
);

    typedef enum logic [2:0] {
        S_ADC,
        S_DSP,
        S_CORE,
        RUN,
        DONE,
        FAIL
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] stage_delay;
    logic             stage_hit;
    logic             cycle_sat;
    logic             timeout;

    // Pick the live hold delay of the stage currently being sequenced.
    always_comb begin
        stage_delay = '0;
        unique case (state)
            S_ADC:   stage_delay = adc_delay;
            S_DSP:   stage_delay = dsp_delay;
            S_CORE:  stage_delay = core_delay;
            default: stage_delay = '0;
        endcase
    end

    assign stage_hit = (count >= stage_delay);
    assign cycle_sat = &cycle_count;

`ifdef RESET_SEQ_WATCHDOG_EN
    logic [CYC_W:0] cycle_plus1;

    // One extra bit keeps the +1 compare correct at saturation.
    assign cycle_plus1 = {1'b0, cycle_count} + {{CYC_W{1'b0}}, 1'b1};
    assign timeout     = (max_cycles != '0) &&
                         (cycle_plus1 >= {1'b0, max_cycles});
`else
    logic unused_max_cycles;

    assign unused_max_cycles = ^max_cycles;
    assign timeout           = 1'b0;
`endif

    // Sequencer FSM; every output is a flop written only here.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= S_ADC;
            count       <= '0;
            adc_reset   <= 1'b1;
            dsp_reset   <= 1'b1;
            core_reset  <= 1'b1;
            running     <= 1'b0;
            done        <= 1'b0;
            failed      <= 1'b0;
            cycle_count <= '0;
        end else if (soft_reset) begin
            state       <= S_ADC;
            count       <= '0;
            adc_reset   <= 1'b1;
            dsp_reset   <= 1'b1;
            core_reset  <= 1'b1;
            running     <= 1'b0;
            done        <= 1'b0;
            failed      <= 1'b0;
            cycle_count <= '0;
        end else begin
            unique case (state)
                S_ADC: begin
                    if (stage_hit) begin
                        adc_reset <= 1'b0;
                        count     <= '0;
                        state     <= S_DSP;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                S_DSP: begin
                    if (stage_hit) begin
                        dsp_reset <= 1'b0;
                        count     <= '0;
                        state     <= S_CORE;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                S_CORE: begin
                    if (stage_hit) begin
                        core_reset  <= 1'b0;
                        count       <= '0;
                        running     <= 1'b1;
                        cycle_count <= '0;
                        state       <= RUN;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                RUN: begin
                    if (success) begin
                        done    <= 1'b1;
                        running <= 1'b0;
                        state   <= DONE;
                    end else if (timeout) begin
                        failed  <= 1'b1;
                        running <= 1'b0;
                        state   <= FAIL;
                    end else if (!cycle_sat) begin
                        cycle_count <= cycle_count + 1'b1;
                    end
                end
                DONE: begin
                    state <= DONE;
                end
                FAIL: begin
                    state <= FAIL;
                end
                default: begin
                    state <= S_ADC;
                end
            endcase
        end
    end

    // A later domain may never leave reset ahead of an earlier one.
    release_order: assert property (
        @(posedge clock) disable iff (reset)
        !(adc_reset && !dsp_reset) && !(dsp_reset && !core_reset)
    );

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: directed checks of release timing, run outcome,
// soft restart, live delay change and async reset.
module tb_reset_sequencer;

    logic        clock;
    logic        reset;
    logic        soft_reset;
    logic [15:0] adc_delay;
    logic [15:0] dsp_delay;
    logic [15:0] core_delay;
    logic [63:0] max_cycles;
    logic        success;
    logic        adc_reset;
    logic        dsp_reset;
    logic        core_reset;
    logic        running;
    logic        done;
    logic        failed;
    logic [63:0] cycle_count;

    int n_pass;
    int n_total;

    reset_sequencer #(
        .CNT_W(16),
        .CYC_W(64)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .soft_reset (soft_reset),
        .adc_delay  (adc_delay),
        .dsp_delay  (dsp_delay),
        .core_delay (core_delay),
        .max_cycles (max_cycles),
        .success    (success),
        .adc_reset  (adc_reset),
        .dsp_reset  (dsp_reset),
        .core_reset (core_reset),
        .running    (running),
        .done       (done),
        .failed     (failed),
        .cycle_count(cycle_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Pulse async reset between edges; the next edge is edge 1.
    task automatic pulse_reset();
        reset = 1'b1;
        #2;
        reset = 1'b0;
    endtask

    // Expected falling edges of adc/dsp/core reset, hand-computed.
    task automatic run_seq(input int ea, input int ed, input int ec);
        logic [3:0] exp;
        for (int e = 1; e <= ec; e++) begin
            step();
            exp = {e < ea, e < ed, e < ec, e >= ec};
            check($sformatf("seq_e%0d", e),
                  {60'd0, adc_reset, dsp_reset, core_reset, running},
                  {60'd0, exp});
        end
    endtask

    initial begin
        n_pass     = 0;
        n_total    = 0;
        reset      = 1'b1;
        soft_reset = 1'b0;
        adc_delay  = 16'd3;
        dsp_delay  = 16'd2;
        core_delay = 16'd1;
        max_cycles = 64'd0;
        success    = 1'b0;

        #12;
        check("rst_resets",
              {61'd0, adc_reset, dsp_reset, core_reset}, 64'h7);
        check("rst_flags", {61'd0, running, done, failed}, 64'h0);
        check("rst_cycles", cycle_count, 64'd0);
        #1;
        reset = 1'b0;

        // 3/2/1 delays: falls at edges 4, 7, 9
        run_seq(4, 7, 9);
        step();
        check("run_cnt1", cycle_count, 64'd1);
        success = 1'b1;
        step();
        success = 1'b0;
        check("succ_done", {63'd0, done}, 64'd1);
        check("succ_run", {63'd0, running}, 64'd0);
        check("succ_fail", {63'd0, failed}, 64'd0);
        check("succ_cnt", cycle_count, 64'd1);
        step();
        step();
        check("done_hold", {63'd0, done}, 64'd1);
        check("done_cnt", cycle_count, 64'd1);
        check("done_rel",
              {61'd0, adc_reset, dsp_reset, core_reset}, 64'h0);

        // soft reset held for two cycles
        soft_reset = 1'b1;
        step();
        check("soft1_rst",
              {61'd0, adc_reset, dsp_reset, core_reset}, 64'h7);
        check("soft1_flags", {61'd0, running, done, failed}, 64'h0);
        check("soft1_cnt", cycle_count, 64'd0);
        step();
        check("soft2_rst",
              {61'd0, adc_reset, dsp_reset, core_reset}, 64'h7);
        soft_reset = 1'b0;
        run_seq(4, 7, 9);
        check("rerun_done", {63'd0, done}, 64'd0);

        // all-zero delays; success ignored while sequencing
        adc_delay  = 16'd0;
        dsp_delay  = 16'd0;
        core_delay = 16'd0;
        success    = 1'b1;
        pulse_reset();
        run_seq(1, 2, 3);
        check("ign_succ_done", {63'd0, done}, 64'd0);
        success = 1'b0;

        // watchdog limit 10 with success held low
        max_cycles = 64'd10;
        pulse_reset();
        run_seq(1, 2, 3);
        for (int i = 0; i < 9; i++) step();
        check("wd9_run", {63'd0, running}, 64'd1);
        check("wd9_cnt", cycle_count, 64'd9);
        step();
`ifdef RESET_SEQ_WATCHDOG_EN
        check("wd_failed", {63'd0, failed}, 64'd1);
        check("wd_run", {63'd0, running}, 64'd0);
        check("wd_cnt", cycle_count, 64'd9);
        check("wd_done", {63'd0, done}, 64'd0);
        step();
        check("wd_hold_cnt", cycle_count, 64'd9);
        check("wd_hold_fail", {63'd0, failed}, 64'd1);
`else
        check("nowd_failed", {63'd0, failed}, 64'd0);
        check("nowd_run", {63'd0, running}, 64'd1);
        check("nowd_cnt", cycle_count, 64'd10);
        step();
        check("nowd_cnt2", cycle_count, 64'd11);
`endif

        // success on the same edge the timeout would fire
        max_cycles = 64'd5;
        pulse_reset();
        run_seq(1, 2, 3);
        for (int i = 0; i < 4; i++) step();
        success = 1'b1;
        step();
        success = 1'b0;
        check("tie_done", {63'd0, done}, 64'd1);
        check("tie_failed", {63'd0, failed}, 64'd0);
        check("tie_cnt", cycle_count, 64'd4);
        max_cycles = 64'd0;

        // lower dsp_delay 8->2 while its counter sits at 5
        dsp_delay = 16'd8;
        pulse_reset();
        for (int i = 0; i < 6; i++) step();
        check("live_hold",
              {61'd0, adc_reset, dsp_reset, core_reset}, 64'h3);
        dsp_delay = 16'd2;
        step();
        check("live_rel",
              {61'd0, adc_reset, dsp_reset, core_reset}, 64'h1);
        step();
        check("live_run", {63'd0, running}, 64'd1);

        // async reset while in S_CORE
        dsp_delay  = 16'd0;
        core_delay = 16'd5;
        pulse_reset();
        for (int i = 0; i < 3; i++) step();
        check("core_pre",
              {61'd0, adc_reset, dsp_reset, core_reset}, 64'h1);
        reset = 1'b1;
        #1;
        check("async_rst",
              {61'd0, adc_reset, dsp_reset, core_reset}, 64'h7);
        check("async_run", {63'd0, running}, 64'd0);
        reset = 1'b0;
        run_seq(1, 2, 8);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Sequences reset release for the chip's three reset domains in a fixed order: ADC clock generator, then DSP, then core.
- After release, runs a cycle watchdog and latches the run outcome (success or timeout) for the harness/driver level.
- Replaces free-running fixed-delay reset timing with a cycle-accurate, reprogrammable sequence that can be re-triggered without a global reset.

Parameters:
- CNT_W, 16, width of each per-stage hold-delay counter and config input.
- CYC_W, 64, width of the run-cycle counter and max_cycles input.

Ports:
- clock  in  1  sequencer clock.
- reset  in  1  asynchronous, active-high global reset.
- soft_reset  in  1  synchronous level request to restart the sequence.
- adc_delay  in  CNT_W  hold cycles before adc_reset releases.
- dsp_delay  in  CNT_W  hold cycles after adc release before dsp_reset releases.
- core_delay  in  CNT_W  hold cycles after dsp release before core_reset releases.
- max_cycles  in  CYC_W  run watchdog limit; 0 = disabled.
- success  in  1  completion indication from the design under control.
- adc_reset  out  1  ADC clock-gen reset, active high.
- dsp_reset  out  1  DSP reset, active high.
- core_reset  out  1  core reset, active high.
- running  out  1  high in RUN state.
- done  out  1  sticky success.
- failed  out  1  sticky timeout.
- cycle_count  out  CYC_W  cycles elapsed in RUN.

Behaviour:
- States: S_ADC, S_DSP, S_CORE, RUN, DONE, FAIL. All outputs are registered.
- Reset (async assert): state=S_ADC, stage counter=0, adc/dsp/core_reset=1, running=done=failed=0, cycle_count=0.
- S_ADC: counter increments each edge. When counter >= adc_delay, the edge clears adc_reset, clears the counter and moves to S_DSP. adc_reset is therefore low adc_delay+1 edges after reset deasserts; delay 0 gives release on the first edge.
- S_DSP: same rule with dsp_delay, clearing dsp_reset; then S_CORE.
- S_CORE: same rule with core_delay, clearing core_reset; then RUN with running=1.
- Release order is guaranteed: an earlier-stage reset is never high while a later one is low.
- Config inputs are sampled live, and the compare is >=. Lowering a delay below the current count releases that stage on the next edge.
- RUN: cycle_count increments by 1 per edge and saturates at all-ones.
  - success=1 at an edge -> DONE: done=1, running=0, cycle_count frozen.
  - Otherwise, if the watchdog is enabled, max_cycles != 0 and cycle_count+1 >= max_cycles at that edge -> FAIL: failed=1, running=0.
  - success and timeout on the same edge: success wins.
- success is ignored outside RUN.
- DONE and FAIL are terminal until reset or soft_reset. Resets stay released in both.
- soft_reset=1 at any edge, in any state: next state S_ADC, all three resets=1, counters=0, running/done/failed=0. While soft_reset is held, the FSM stays in S_ADC with the counter at 0. The sequence restarts on the first edge with soft_reset=0.
- Async reset mid-sequence: immediate return to reset values, no glitch-free requirement on the reset outputs beyond the flops.

Optional Feature:
- Macro RESET_SEQ_WATCHDOG_EN.
- Defined: max_cycles timeout and the FAIL transition behave as above.
- Undefined: max_cycles is ignored, failed is tied 0, FAIL is unreachable, and RUN exits only via success. cycle_count still counts.

Test Plan:
- Delays: adc=3, dsp=2, core=1, release reset at edge 0 -> adc_reset falls at edge 4, dsp_reset at edge 7, core_reset at edge 9, running=1 from edge 9.
- All delays 0 -> resets fall on edges 1, 2, 3 in order; running=1 at edge 3.
- Watchdog build, max_cycles=10, success held 0 -> failed=1, running=0, cycle_count=9 after the 10th RUN edge; done stays 0.
- max_cycles=5, success pulsed on the same edge the timeout would fire -> done=1, failed=0.
- In RUN with done=1, assert soft_reset for 2 cycles -> all resets=1, done=0, cycle_count=0; the sequence reruns with the configured delays after release.
- During S_DSP with counter=5, change dsp_delay 8->2 -> dsp_reset releases on the next edge. Async reset pulse in S_CORE -> immediate all-resets-high.
